// File: rtl/pipe_sel_mux_if.sv
// rtl/pipe_sel_mux_if.sv - handshake bundle for pipe_sel_mux: upstream beat, flush, downstream output.
interface pipe_sel_mux_if #(
  parameter int WIDTH  = 5,
  parameter int NUM_IN = 2,
  parameter int SEL_W  = 1
);
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]        sel;
  logic                    in_valid;
  logic                    in_ready;
  logic                    flush;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    sel_err;

  modport master (
    output in_data, sel, in_valid, flush, out_ready,
    input  in_ready, out_data, out_valid, sel_err
  );

  modport slave (
    input  in_data, sel, in_valid, flush, out_ready,
    output in_ready, out_data, out_valid, sel_err
  );
endinterface

// File: rtl/pipe_sel_mux.sv
// rtl/pipe_sel_mux.sv - N:1 selector behind a registered valid/ready stage with a skid entry.
// Optional sticky out-of-range flag enabled by PIPE_SEL_MUX_SELERR_EN.
module pipe_sel_mux #(
  parameter int               WIDTH       = 5,
  parameter int               NUM_IN      = 2,
  parameter int               SEL_W       = 1,
  parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
  input logic            clk,
  input logic            rst_n,
  pipe_sel_mux_if.slave  bus
);

  logic [WIDTH-1:0] sel_val;
  logic [WIDTH-1:0] main_data;
  logic             main_valid;
  logic [WIDTH-1:0] skid_data;
  logic             skid_valid;
  logic             accept;
  logic             main_free;

  always_comb begin
    sel_val = DEFAULT_VAL;
    for (int k = 0; k < NUM_IN; k++) begin
      if (bus.sel == SEL_W'(k)) sel_val = bus.in_data[k*WIDTH +: WIDTH];
    end
  end

  // in_ready depends only on registered state, so out_ready never reaches it.
  assign accept    = bus.in_valid && !skid_valid;
  assign main_free = !main_valid || bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_data  <= DEFAULT_VAL;
      main_valid <= 1'b0;
      skid_data  <= DEFAULT_VAL;
      skid_valid <= 1'b0;
    end else if (bus.flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (main_free) begin
      if (skid_valid) begin
        main_data  <= skid_data;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else if (accept) begin
        main_data  <= sel_val;
        main_valid <= 1'b1;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_data  <= sel_val;
      skid_valid <= 1'b1;
    end
  end

  assign bus.in_ready  = !skid_valid;
  assign bus.out_data  = main_data;
  assign bus.out_valid = main_valid;

`ifdef PIPE_SEL_MUX_SELERR_EN
  logic sel_oor;
  logic sel_err_q;

  assign sel_oor = {{(32-SEL_W){1'b0}}, bus.sel} >= 32'(NUM_IN);

  // Sticky until reset; flush deliberately leaves it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err_q <= 1'b0;
    end else if (accept && sel_oor) begin
      sel_err_q <= 1'b1;
    end
  end

  assign bus.sel_err = sel_err_q;
`else
  assign bus.sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_sel_mux.sv
// tb/tb_pipe_sel_mux.sv - directed bench for pipe_sel_mux in three configurations.
module tb_pipe_sel_mux;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

`ifdef PIPE_SEL_MUX_SELERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  pipe_sel_mux_if #(.WIDTH(5),  .NUM_IN(2), .SEL_W(1)) if_a ();
  pipe_sel_mux_if #(.WIDTH(5),  .NUM_IN(3), .SEL_W(2)) if_b ();
  pipe_sel_mux_if #(.WIDTH(32), .NUM_IN(8), .SEL_W(3)) if_c ();

  pipe_sel_mux #(.WIDTH(5), .NUM_IN(2), .SEL_W(1), .DEFAULT_VAL(5'h00)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a.slave));
  pipe_sel_mux #(.WIDTH(5), .NUM_IN(3), .SEL_W(2), .DEFAULT_VAL(5'h1F)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b.slave));
  pipe_sel_mux #(.WIDTH(32), .NUM_IN(8), .SEL_W(3), .DEFAULT_VAL(32'h0)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(if_c.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    if_a.in_data = '0; if_a.sel = '0; if_a.in_valid = 0; if_a.flush = 0; if_a.out_ready = 0;
    if_b.in_data = '0; if_b.sel = '0; if_b.in_valid = 0; if_b.flush = 0; if_b.out_ready = 0;
    if_c.in_data = '0; if_c.sel = '0; if_c.in_valid = 0; if_c.flush = 0; if_c.out_ready = 0;
    rst_n = 1'b0;
    #12;
    checks++;
    if (if_a.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", if_a.out_valid); end
    checks++;
    if (if_a.out_data !== 5'h00) begin errors++; $display("FAIL reset_out_data_a got %h exp 00", if_a.out_data); end
    checks++;
    if (if_b.out_data !== 5'h1F) begin errors++; $display("FAIL reset_out_data_b got %h exp 1f", if_b.out_data); end
    checks++;
    if (if_a.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", if_a.in_ready); end
    checks++;
    if (if_b.sel_err !== 1'b0) begin errors++; $display("FAIL reset_sel_err got %b exp 0", if_b.sel_err); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_stream();
    if_a.out_ready = 1;
    if_a.in_data = {5'h1C, 5'h03};
    if_a.sel = 1'b1;
    if_a.in_valid = 1;
    step();
    checks++;
    if (if_a.out_valid !== 1'b1 || if_a.out_data !== 5'h1C) begin
      errors++; $display("FAIL stream_beat0 got v=%b d=%h exp v=1 d=1c", if_a.out_valid, if_a.out_data); end
    if_a.sel = 1'b0;
    step();
    checks++;
    if (if_a.out_valid !== 1'b1 || if_a.out_data !== 5'h03) begin
      errors++; $display("FAIL stream_beat1 got v=%b d=%h exp v=1 d=03", if_a.out_valid, if_a.out_data); end
    if_a.in_valid = 0;
    step();
    checks++;
    if (if_a.out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got %b exp 0", if_a.out_valid); end
  endtask

  task automatic test_backpressure();
    if_a.out_ready = 0;
    if_a.sel = 1'b0;
    if_a.in_valid = 1;
    if_a.in_data = {5'h00, 5'h01};
    step();
    checks++;
    if (if_a.out_data !== 5'h01 || if_a.in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_first got d=%h rdy=%b exp d=01 rdy=1", if_a.out_data, if_a.in_ready); end
    if_a.in_data = {5'h00, 5'h02};
    step();
    checks++;
    if (if_a.out_data !== 5'h01 || if_a.in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_skid got d=%h rdy=%b exp d=01 rdy=0", if_a.out_data, if_a.in_ready); end
    if_a.in_data = {5'h00, 5'h03};
    step();
    checks++;
    if (if_a.out_data !== 5'h01 || if_a.out_valid !== 1'b1 || if_a.in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_hold got d=%h v=%b rdy=%b exp d=01 v=1 rdy=0", if_a.out_data, if_a.out_valid, if_a.in_ready); end
    if_a.out_ready = 1;
    step();
    checks++;
    if (if_a.out_data !== 5'h02 || if_a.in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release0 got d=%h rdy=%b exp d=02 rdy=1", if_a.out_data, if_a.in_ready); end
    step();
    checks++;
    if (if_a.out_data !== 5'h03 || if_a.out_valid !== 1'b1) begin
      errors++; $display("FAIL bp_release1 got d=%h v=%b exp d=03 v=1", if_a.out_data, if_a.out_valid); end
    if_a.in_valid = 0;
    step();
    checks++;
    if (if_a.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b exp 0", if_a.out_valid); end
  endtask

  task automatic test_flush();
    if_a.out_ready = 0;
    if_a.sel = 1'b0;
    if_a.in_valid = 1;
    if_a.in_data = {5'h00, 5'h04};
    step();
    if_a.in_data = {5'h00, 5'h05};
    step();
    checks++;
    if (if_a.in_ready !== 1'b0) begin errors++; $display("FAIL flush_setup got rdy=%b exp 0", if_a.in_ready); end
    if_a.flush = 1;
    if_a.in_data = {5'h00, 5'h06};
    step();
    checks++;
    if (if_a.out_valid !== 1'b0 || if_a.in_ready !== 1'b1 || if_a.out_data !== 5'h04) begin
      errors++; $display("FAIL flush_effect got v=%b rdy=%b d=%h exp v=0 rdy=1 d=04", if_a.out_valid, if_a.in_ready, if_a.out_data); end
    if_a.flush = 0;
    if_a.in_valid = 0;
    if_a.out_ready = 1;
    step();
    checks++;
    if (if_a.out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_ghost got v=%b exp 0", if_a.out_valid); end
  endtask

  task automatic test_out_of_range();
    if_b.out_ready = 1;
    if_b.in_data = {5'h03, 5'h02, 5'h01};
    if_b.sel = 2'd3;
    if_b.in_valid = 1;
    step();
    checks++;
    if (if_b.out_data !== 5'h1F || if_b.out_valid !== 1'b1) begin
      errors++; $display("FAIL oor_default got d=%h v=%b exp d=1f v=1", if_b.out_data, if_b.out_valid); end
    checks++;
    if (if_b.sel_err !== EXP_ERR) begin errors++; $display("FAIL oor_sel_err got %b exp %b", if_b.sel_err, EXP_ERR); end
    if_b.sel = 2'd1;
    step();
    checks++;
    if (if_b.out_data !== 5'h02) begin errors++; $display("FAIL oor_inrange got %h exp 02", if_b.out_data); end
    if_b.in_valid = 0;
    if_b.flush = 1;
    step();
    if_b.flush = 0;
    checks++;
    if (if_b.out_valid !== 1'b0 || if_b.sel_err !== EXP_ERR) begin
      errors++; $display("FAIL oor_after_flush got v=%b err=%b exp v=0 err=%b", if_b.out_valid, if_b.sel_err, EXP_ERR); end
  endtask

  task automatic test_async_reset();
    if_a.out_ready = 0;
    if_a.sel = 1'b1;
    if_a.in_valid = 1;
    if_a.in_data = {5'h07, 5'h00};
    step();
    if_a.in_data = {5'h08, 5'h00};
    step();
    if_a.in_valid = 0;
    checks++;
    if (if_a.out_data !== 5'h07 || if_a.in_ready !== 1'b0) begin
      errors++; $display("FAIL areset_setup got d=%h rdy=%b exp d=07 rdy=0", if_a.out_data, if_a.in_ready); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (if_a.out_valid !== 1'b0 || if_a.out_data !== 5'h00 || if_a.in_ready !== 1'b1) begin
      errors++; $display("FAIL areset_a got v=%b d=%h rdy=%b exp v=0 d=00 rdy=1", if_a.out_valid, if_a.out_data, if_a.in_ready); end
    checks++;
    if (if_b.out_data !== 5'h1F || if_b.sel_err !== 1'b0) begin
      errors++; $display("FAIL areset_b got d=%h err=%b exp d=1f err=0", if_b.out_data, if_b.sel_err); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_wide();
    for (int k = 0; k < 8; k++) if_c.in_data[k*32 +: 32] = 32'hA0 + 32'(k);
    if_c.out_ready = 1;
    if_c.in_valid = 1;
    for (int i = 0; i < 8; i++) begin
      if_c.sel = 3'(i);
      step();
      checks++;
      if (if_c.out_data !== 32'hA0 + 32'(i) || if_c.out_valid !== 1'b1) begin
        errors++; $display("FAIL wide_sel%0d got d=%h v=%b exp d=%h v=1", i, if_c.out_data, if_c.out_valid, 32'hA0 + 32'(i)); end
    end
    if_c.in_valid = 0;
    step();
    checks++;
    if (if_c.out_valid !== 1'b0) begin errors++; $display("FAIL wide_drain got %b exp 0", if_c.out_valid); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_out_of_range();
    test_async_reset();
    test_wide();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
